// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a two-entry skid buffer between stages.
// Control of invalid entries is forced to zero so bubbles never carry side effects.
module pipe_stage_reg #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    input  logic              i_flush,
    input  logic              i_cnt_clr,
    output logic [1:0]        o_level,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // The encoding equals the number of held entries, so o_level is the state itself.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_data, main_data_nxt;
    logic [DATA_W-1:0] skid_data, skid_data_nxt;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_nxt;
    logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              accept;
    logic              send;

    // Ready comes from registered state only, never from i_ready.
    assign o_ready     = (state != S_FULL) & ~rst;
    assign o_valid     = (state != S_EMPTY);
    assign accept      = i_valid & o_ready;
    assign send        = o_valid & i_ready;
    assign o_data      = main_data;
    assign o_ctrl      = main_ctrl;
    assign o_level     = state;
    assign o_stall_cnt = stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state     <= state_nxt;
            main_data <= main_data_nxt;
            main_ctrl <= main_ctrl_nxt;
            skid_data <= skid_data_nxt;
            skid_ctrl <= skid_ctrl_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        main_data_nxt = main_data;
        main_ctrl_nxt = main_ctrl;
        skid_data_nxt = skid_data;
        skid_ctrl_nxt = skid_ctrl;
        case (state)
            S_EMPTY: begin
                if (accept) begin
                    main_data_nxt = i_data;
                    main_ctrl_nxt = i_ctrl;
                    state_nxt     = S_ONE;
                end
            end
            S_ONE: begin
                if (send && accept) begin
                    main_data_nxt = i_data;
                    main_ctrl_nxt = i_ctrl;
                end else if (send) begin
                    main_ctrl_nxt = '0;
                    state_nxt     = S_EMPTY;
                end else if (accept) begin
                    skid_data_nxt = i_data;
                    skid_ctrl_nxt = i_ctrl;
                    state_nxt     = S_FULL;
                end
            end
            S_FULL: begin
                // The skid entry moves up; nothing can be accepted while full.
                if (send) begin
                    main_data_nxt = skid_data;
                    main_ctrl_nxt = skid_ctrl;
                    skid_ctrl_nxt = '0;
                    state_nxt     = S_ONE;
                end
            end
            default: begin
                main_ctrl_nxt = '0;
                skid_ctrl_nxt = '0;
                state_nxt     = S_EMPTY;
            end
        endcase
        if (i_flush) begin
            main_ctrl_nxt = '0;
            skid_ctrl_nxt = '0;
            state_nxt     = S_EMPTY;
        end
    end

    // Saturating stall counter; clear wins over increment, flush does not touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (i_cnt_clr) begin
            stall_cnt <= '0;
        end else if (o_valid && !i_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, the successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches. It carries a generic data bundle and a control bundle between stages using a valid/ready handshake, and uses a two-entry skid buffer so back-pressure does not create a combinational ready path. Flush inserts bubbles: valid is cleared and control is zeroed, so no RegWrite or MemWrite can leak downstream. A saturating stall counter gives performance visibility.

## Interface
Parameters:
- DATA_W, 128: width of the data bundle (register values, PC, immediates, addresses).
- CTRL_W, 16: width of the control bundle (RegDst, MemRead, MemWrite, MemtoReg, ALUop, …). It is zeroed on bubbles.
- CNT_W, 16: width of the stall counter.

Ports:
- clk, in, 1: single clock. All state changes on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- i_valid, in, 1: upstream holds a valid entry.
- o_ready, out, 1: stage can accept an entry this cycle.
- i_data, in, DATA_W: upstream data bundle.
- i_ctrl, in, CTRL_W: upstream control bundle.
- o_valid, out, 1: downstream entry valid.
- i_ready, in, 1: downstream accepts this cycle.
- o_data, out, DATA_W: data of the head entry.
- o_ctrl, out, CTRL_W: control of the head entry. It is all-zero whenever o_valid=0.
- i_flush, in, 1: synchronous flush, which discards all held entries.
- i_cnt_clr, in, 1: synchronous clear of the stall counter.
- o_level, out, 2: number of entries held (0–2).
- o_stall_cnt, out, CNT_W: saturating count of cycles with o_valid=1 and i_ready=0.

## Operation
- Storage:
  - Head register (main) drives o_data/o_ctrl.
  - Skid register holds the overflow entry.
- States:
  - EMPTY: level 0.
  - ONE: main valid.
  - FULL: main and skid valid.
- Handshakes:
  - accept = i_valid & o_ready.
  - send = o_valid & i_ready.
- o_ready = (state != FULL) & ~rst. It is decoded from registered state only and never depends combinationally on i_ready.
- o_valid = (state != EMPTY).
- Transitions (no flush):
  - EMPTY:
    - accept: main ← input, go to ONE.
    - otherwise: stay in EMPTY.
  - ONE:
    - send & accept: main ← input, stay in ONE.
    - send only: go to EMPTY, main ctrl ← 0.
    - accept only: skid ← input, go to FULL.
    - neither: hold.
  - FULL (no accept possible):
    - send: main ← skid, go to ONE, skid ctrl ← 0.
    - otherwise: hold.
- Flush has top priority over every transition:
  - Next state is EMPTY.
  - main ctrl and skid ctrl ← 0.
  - An input accepted in the same cycle is dropped.
  - A send in the same cycle still completes downstream; it is the downstream consumer's responsibility to qualify it.
- Data fields of invalid entries retain their last value (don't-care). Control fields of invalid entries are always zero.
- Order is strictly FIFO: the skid entry is never overtaken.
- Stall counter:
  - Increments when o_valid & ~i_ready.
  - Saturates at 2^CNT_W−1.
  - i_cnt_clr sets it to 0, with priority over increment.
  - It is unaffected by i_flush.

## Timing
- Reset (async assert, applied immediately):
  - state EMPTY.
  - o_valid=0, o_ready=0, o_level=0, o_stall_cnt=0.
  - o_data=0, o_ctrl=0.
- o_ready rises in the same cycle rst deasserts (combinational on state and rst). The first accept can occur on the first edge after deassertion.
- Latency:
  - An entry accepted at edge N appears on o_data/o_valid after edge N when the stage was EMPTY, or when it was ONE with a simultaneous send.
  - Otherwise it appears one edge after the blocking entry leaves.
- Throughput is 1 entry per cycle with i_ready held high.
- o_ready falls after the edge that makes the state FULL. It rises after the edge on which a send occurs in FULL.
- Flush takes effect at the edge where i_flush=1. The cycle after, o_valid=0, o_ctrl=0, o_level=0 and o_ready=1.
- Reset mid-operation discards all entries immediately. No partial state survives.

## Test plan
- Reset then stream: push data 0x1..0x8 with ctrl 0xA5A5 and i_ready=1 → o_valid high from the cycle after the first accept, one entry per cycle, in order, o_level ≤1, o_stall_cnt=0.
- Back-pressure: push 0x11, 0x22, 0x33 with i_ready=0 → 0x11 and 0x22 held, o_level=2, o_ready=0, 0x33 held upstream. Then raise i_ready → outputs 0x11, 0x22, 0x33 on consecutive cycles, o_stall_cnt equals the stalled cycle count.
- Flush while FULL: o_level=2, assert i_flush with i_valid=1 (data 0x44) → next cycle o_valid=0, o_ctrl=0, o_level=0, o_ready=1, and 0x44 is never emitted.
- Reset mid-stream: assert rst asynchronously between edges while o_level=2 → o_valid, o_ctrl, o_level and o_stall_cnt go to 0 immediately, and o_ready=0 until rst deasserts.
- Counter saturation: CNT_W=4, hold o_valid=1 and i_ready=0 for 20 cycles → o_stall_cnt stops at 15. i_cnt_clr concurrent with a stall cycle → 0.
- Random handshake: random i_valid/i_ready/i_flush against a scoreboard → FIFO order preserved, no duplicates, no non-zero o_ctrl while o_valid=0.
